// File: rtl/nn_stream_decoder_if.sv
// Handshake and data bundle between the burst gate cluster, the decoder and its consumer.
// The master side drives control and samples; the slave (decoder) returns status and result.
interface nn_stream_decoder_if #(
  parameter int unsigned WIDTH = 4
);
  logic                    START;
  logic                    ABORT;
  logic                    IN;
  logic                    EN;
  logic                    ACK;
  logic                    BUSY;
  logic                    VALID;
  logic [WIDTH:0]          COUNT;
  logic signed [WIDTH+1:0] VALUE;

  modport master (
    output START, ABORT, IN, EN, ACK,
    input  BUSY, VALID, COUNT, VALUE
  );

  modport slave (
    input  START, ABORT, IN, EN, ACK,
    output BUSY, VALID, COUNT, VALUE
  );
endinterface

// File: rtl/nn_stream_decoder.sv
// Counts ones in a stochastic bitstream over 2^WIDTH enabled samples after an optional settle
// period, presenting the result as an unsigned count and a bipolar value with VALID/ACK handshake.
module nn_stream_decoder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 16
) (
  input logic                CLK,
  input logic                RSTn,
  nn_stream_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [WIDTH+1:0] ONE_W       = {{(WIDTH+1){1'b0}}, 1'b1};
  localparam logic [WIDTH+1:0] FULL_SCALE  = ONE_W << WIDTH;
  localparam logic [WIDTH+1:0] VALUE_RESET = ~FULL_SCALE + ONE_W;

  state_t                  state;
  logic [SW-1:0]           settle_cnt;
  logic [WIDTH-1:0]        win_cnt;
  logic [WIDTH:0]          acc;
  logic [WIDTH:0]          count_r;
  logic signed [WIDTH+1:0] value_r;
  logic                    busy_r;
  logic                    valid_r;

  logic [WIDTH:0]          sample_sum;
  logic                    win_last;

  // Sum including the current sample, so the final window value is captured on the same edge
  assign sample_sum = acc + {{WIDTH{1'b0}}, bus.IN};
  assign win_last   = &win_cnt;

  assign bus.BUSY  = busy_r;
  assign bus.VALID = valid_r;
  assign bus.COUNT = count_r;
  assign bus.VALUE = value_r;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      count_r    <= '0;
      value_r    <= VALUE_RESET;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else if (bus.ABORT) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            acc        <= '0;
            busy_r     <= 1'b1;
            valid_r    <= 1'b0;
            state      <= (SETTLE == 0) ? S_ACCUM : S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (bus.EN) begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= S_ACCUM;
            end else begin
              settle_cnt <= settle_cnt + {{(SW-1){1'b0}}, 1'b1};
            end
          end
        end

        S_ACCUM: begin
          if (bus.EN) begin
            acc     <= sample_sum;
            win_cnt <= win_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
            if (win_last) begin
              count_r <= sample_sum;
              value_r <= {sample_sum, 1'b0} - FULL_SCALE;
              busy_r  <= 1'b0;
              valid_r <= 1'b1;
              state   <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (bus.ACK) begin
            valid_r <= 1'b0;
            if (bus.START) begin
              // Upstream is already settled: restart the window without a settle period
              win_cnt <= '0;
              acc     <= '0;
              busy_r  <= 1'b1;
              state   <= S_ACCUM;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_stream_decoder.sv
// Self-checking bench for nn_stream_decoder: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a window-counting reference model.
module tb_nn_stream_decoder;

  localparam int unsigned W   = 4;
  localparam int unsigned ST  = 4;
  localparam int          WIN = 16;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  nn_stream_decoder_if #(.WIDTH(W)) bus();

  nn_stream_decoder #(.WIDTH(W), .SETTLE(ST)) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic start;
    logic abort;
    logic en;
    logic in_bit;
    logic ack;
    logic exp_busy;
    logic exp_valid;
    int   exp_count;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic s, input logic a, input logic e, input logic i, input logic k);
    bus.START = s;
    bus.ABORT = a;
    bus.EN    = e;
    bus.IN    = i;
    bus.ACK   = k;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic eb, input logic ev, input int ec);
    int                  val_int;
    logic [W:0]          expc;
    logic signed [W+1:0] expv;
    val_int = 2 * ec - WIN;
    expc    = ec[W:0];
    expv    = val_int[W+1:0];
    vectors++;
    if (bus.BUSY !== eb || bus.VALID !== ev || bus.COUNT !== expc || bus.VALUE !== expv) begin
      miscompares++;
      $display("FAIL %s: got busy=%0b valid=%0b count=%0d value=%0d, want busy=%0b valid=%0b count=%0d value=%0d",
               name, bus.BUSY, bus.VALID, bus.COUNT, bus.VALUE, eb, ev, expc, expv);
    end
  endtask

  // One full conversion from IDLE: START on row 0, ACK on ack_row, one idle row after.
  // en_mode 0: always enabled, 1: enabled on even rows. in_mode 0: ones, 1: alternating, 2: zeros, 3: ~EN.
  function automatic void add_run(input int en_mode, input int in_mode, input int busy_last,
                                  input int ack_row, input int prev, input int res, input bit pulses);
    for (int r = 0; r <= ack_row + 1; r++) begin
      vec_t v;
      v.start = (r == 0);
      v.abort = 1'b0;
      v.ack   = (r == ack_row);
      v.en    = (en_mode == 0) ? 1'b1 : (r % 2 == 0);
      case (in_mode)
        0:       v.in_bit = 1'b1;
        1:       v.in_bit = (r % 2 == 1);
        2:       v.in_bit = 1'b0;
        default: v.in_bit = ~v.en;
      endcase
      if (pulses && (r == 3 || r == 12)) v.start = 1'b1;
      if (pulses && r == 9) v.ack = 1'b1;
      v.exp_busy  = (r <= busy_last);
      v.exp_valid = (r > busy_last) && (r < ack_row);
      v.exp_count = (r <= busy_last) ? prev : res;
      tbl.push_back(v);
    end
  endfunction

  logic en_a[200];
  logic in_a[200];
  int   cur_count;
  int   comp, res, e_cnt, abort_row, launch_settle, choice, n_hold;
  bit   from_idle, aborted;

  initial begin
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset", 1'b0, 1'b0, 0);
    RSTn = 1'b1;
    tick();
    check("idle_after_reset", 1'b0, 1'b0, 0);

    add_run(0, 0, 19, 23, 0, 16, 1'b0);
    add_run(0, 1, 19, 23, 16, 8, 1'b0);
    add_run(0, 2, 19, 23, 8, 0, 1'b0);
    add_run(1, 3, 39, 42, 0, 0, 1'b0);
    add_run(0, 0, 19, 23, 0, 16, 1'b1);

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].start, tbl[n].abort, tbl[n].en, tbl[n].in_bit, tbl[n].ack);
      tick();
      check($sformatf("tbl%0d", n), tbl[n].exp_busy, tbl[n].exp_valid, tbl[n].exp_count);
    end

    // ACK+START in HOLD restarts the window with no settle
    drive(1, 0, 1, 0, 0);
    tick();
    check("b2b_launch", 1'b1, 1'b0, 16);
    for (int k = 1; k < 20; k++) begin
      drive(0, 0, 1, 0, 0);
      tick();
      check("b2b_first_busy", 1'b1, 1'b0, 16);
    end
    drive(0, 0, 1, 0, 0);
    tick();
    check("b2b_first_done", 1'b0, 1'b1, 0);
    drive(1, 0, 1, 1, 1);
    tick();
    check("b2b_restart", 1'b1, 1'b0, 0);
    for (int k = 1; k < 16; k++) begin
      drive(0, 0, 1, 1, 0);
      tick();
      check("b2b_accum", 1'b1, 1'b0, 0);
    end
    drive(0, 0, 1, 1, 0);
    tick();
    check("b2b_second_done", 1'b0, 1'b1, 16);
    drive(0, 0, 1, 1, 1);
    tick();
    check("b2b_ack", 1'b0, 1'b0, 16);

    // Prior result of 8, then ABORT on the 10th ACCUM cycle
    drive(1, 0, 1, 0, 0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 1, (k % 2 == 1), 0);
      tick();
    end
    check("abort_prior_done", 1'b0, 1'b1, 8);
    drive(0, 0, 1, 0, 1);
    tick();
    check("abort_prior_ack", 1'b0, 1'b0, 8);
    drive(1, 0, 1, 1, 0);
    tick();
    for (int k = 1; k <= 13; k++) begin
      drive(0, 0, 1, 1, 0);
      tick();
      check("abort_busy", 1'b1, 1'b0, 8);
    end
    drive(0, 1, 1, 1, 0);
    tick();
    check("abort_idle", 1'b0, 1'b0, 8);
    for (int k = 0; k < 30; k++) begin
      drive(0, 0, 1, 1, 0);
      tick();
      check("abort_stays_idle", 1'b0, 1'b0, 8);
    end

    // Asynchronous reset mid-ACCUM, checked between clock edges
    drive(1, 0, 1, 1, 0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 1, 1, 0);
      tick();
    end
    check("pre_reset_busy", 1'b1, 1'b0, 8);
    #2;
    RSTn = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, 0);
    tick();
    RSTn = 1'b1;
    tick();
    check("post_reset_idle", 1'b0, 1'b0, 0);

    // Randomized transactions against the window-counting model
    cur_count     = 0;
    from_idle     = 1'b1;
    launch_settle = ST;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 200; k++) begin
        en_a[k] = (k >= 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_a[k] = ($urandom_range(0, 1) == 1);
      end
      comp  = -1;
      res   = 0;
      e_cnt = 0;
      for (int k = 1; k < 200; k++) begin
        if (en_a[k]) begin
          if (e_cnt >= launch_settle) res += int'(in_a[k]);
          e_cnt++;
          if (e_cnt == launch_settle + WIN) begin
            comp = k;
            break;
          end
        end
      end
      abort_row = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, comp)) : -1;

      if (from_idle) drive(1, 0, en_a[0], in_a[0], ($urandom_range(0, 1) == 1));
      else           drive(1, 0, en_a[0], in_a[0], 1);
      tick();
      check("rnd_launch", 1'b1, 1'b0, cur_count);

      aborted = 1'b0;
      for (int k = 1; k <= comp; k++) begin
        drive(($urandom_range(0, 3) == 0), (k == abort_row), en_a[k], in_a[k],
              ($urandom_range(0, 3) == 0));
        tick();
        if (k == abort_row) begin
          check("rnd_abort", 1'b0, 1'b0, cur_count);
          aborted = 1'b1;
          break;
        end else if (k == comp) begin
          cur_count = res;
          check("rnd_done", 1'b0, 1'b1, cur_count);
        end else begin
          check("rnd_busy", 1'b1, 1'b0, cur_count);
        end
      end

      if (aborted) begin
        from_idle     = 1'b1;
        launch_settle = ST;
      end else begin
        n_hold = $urandom_range(0, 3);
        for (int h = 0; h < n_hold; h++) begin
          drive(($urandom_range(0, 1) == 1), 0, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), 0);
          tick();
          check("rnd_hold", 1'b0, 1'b1, cur_count);
        end
        choice = $urandom_range(0, 2);
        if (choice == 1) begin
          from_idle     = 1'b0;
          launch_settle = 0;
        end else begin
          drive((choice == 2) && ($urandom_range(0, 1) == 1), (choice == 2), 1'b1,
                ($urandom_range(0, 1) == 1), 1'b1);
          tick();
          check("rnd_release", 1'b0, 1'b0, cur_count);
          from_idle     = 1'b1;
          launch_settle = ST;
        end
      end

      if (from_idle) begin
        drive(0, 0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1));
        tick();
        check("rnd_idle", 1'b0, 1'b0, cur_count);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_stream_decoder.md
Name: nn_stream_decoder

Overview:
Downstream stage of the burst gate cluster. Counts ones in the cluster's stochastic output bitstream over a fixed window of 2^WIDTH enabled samples. Presents the result as an unsigned ones-count and as a bipolar signed value, with a VALID/ACK handshake. A programmable settle period discards samples while the upstream burst memories fill after (re)initialisation.

Parameters:
WIDTH, 4, log2 of window length; window = 2^WIDTH enabled samples
SETTLE, 16, enabled cycles discarded after START from IDLE; 0 = no settle (matches upstream MEMSIZE)

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTn  input  1  asynchronous active-low reset
START  input  1  begin a conversion (accepted only in IDLE or HOLD)
ABORT  input  1  cancel conversion in progress, return to IDLE
IN  input  1  stochastic bitstream from burst gate cluster OUT
EN  input  1  sample enable; SETTLE and ACCUM advance only when EN=1
ACK  input  1  consumer accepts result while VALID=1
BUSY  output  1  1 in SETTLE or ACCUM
VALID  output  1  1 in HOLD (result stable)
COUNT  output  WIDTH+1  ones counted in last completed window, 0..2^WIDTH
VALUE  output  WIDTH+2  signed, 2*COUNT - 2^WIDTH, range -2^WIDTH..+2^WIDTH

Behaviour:
- RSTn low (async, any time, incl. mid-conversion): state=IDLE, all counters 0, BUSY=0, VALID=0, COUNT=0, VALUE=-2^WIDTH (two's complement). Outputs take reset values immediately, without waiting for CLK.
- States: IDLE, SETTLE, ACCUM, HOLD. BUSY and VALID are decoded from state.
- IDLE: START=1 -> SETTLE, or ACCUM when SETTLE=0. Clear window counter and ones accumulator.
- SETTLE: settle counter increments on EN=1. After SETTLE enabled cycles -> ACCUM. IN ignored.
- ACCUM: on each EN=1 cycle, accumulator += IN and window counter += 1. On the 2^WIDTH-th enabled sample:
  - COUNT <= final accumulator (including that sample).
  - VALUE <= 2*final - 2^WIDTH.
  - state -> HOLD.
- Accumulator is WIDTH+1 bits and cannot overflow. Window counter is WIDTH bits; completion is detected at all-ones with EN=1.
- Latency with EN tied high: START at cycle t (IDLE) -> SETTLE occupies t+1..t+SETTLE; samples taken t+SETTLE+1..t+SETTLE+2^WIDTH; VALID=1 from t+SETTLE+2^WIDTH+1.
- HOLD: COUNT/VALUE stable, VALID=1.
  - ACK=1, START=0 -> IDLE.
  - ACK=1 and START=1 same cycle -> ACCUM directly (stream already settled, no settle), counters cleared, VALID=0 next cycle.
  - START without ACK ignored.
- START in SETTLE/ACCUM ignored. ACK outside HOLD ignored.
- ABORT=1 in any state -> IDLE next cycle, VALID=0. COUNT/VALUE keep last completed result. ABORT has priority over START/ACK.
- EN=0 freezes all counters and the state (except ABORT/ACK/START transitions, which are not gated by EN).
- COUNT/VALUE update only at window completion, never on partial windows.

Test Plan:
1. WIDTH=4, SETTLE=4, EN=1, IN=1 constant, START at cycle 0 -> BUSY cycles 1-20, VALID rises cycle 21, COUNT=16, VALUE=+16. ACK cycle 23 -> IDLE cycle 24, VALID=0.
2. IN pattern 1,0 repeating -> COUNT=8, VALUE=0. IN=0 constant -> COUNT=0, VALUE=-16 (6'b110000).
3. EN=1 on even cycles only, IN=0 when EN=1 and IN=1 when EN=0 -> COUNT=0; VALID latency doubles (approx. cycle 41).
4. In HOLD, assert ACK and START together -> next cycle ACCUM, VALID=0, no settle. IN=1 -> VALID again 17 cycles later, COUNT=16.
5. ABORT at cycle 10 of ACCUM after a prior result COUNT=8 -> IDLE next cycle, VALID never asserts, COUNT stays 8. Separately, RSTn low mid-ACCUM -> BUSY=0, COUNT=0 asynchronously.
6. START pulses during SETTLE and ACCUM, ACK during ACCUM -> no effect; result and timing identical to scenario 1.
